btb: RTL



---
 rtl/btb.sv | 94 +++++++++
 1 files changed

// File: rtl/btb.sv
// btb: direct-mapped, tagged branch target buffer with saturating-counter direction prediction.
// Lookup is combinational on the fetch PC; training comes from the EX-stage branchpredict struct.
package btb_pkg;
    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] target_address;
        logic        is_mispredict;
        logic        is_taken;
        logic        is_lower_16;
        logic        valid;
        logic        clear;
    } branchpredict;
endpackage

module btb import btb_pkg::*; #(
    parameter int NR_ENTRIES              = 8,
    parameter int BITS_SATURATION_COUNTER = 2,
    parameter int INDEX_OFFSET            = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic [63:0]  vpc_i,
    input  branchpredict branch_predict_i,
    output logic         predict_valid_o,
    output logic         predict_taken_o,
    output logic [63:0]  predict_address_o,
    output logic         predict_is_lower_16_o
);
    localparam int IB = $clog2(NR_ENTRIES);
    localparam int LO = IB + INDEX_OFFSET;
    localparam int C  = BITS_SATURATION_COUNTER;
    localparam logic [C-1:0] CNT_MAX  = '1;
    localparam logic [C-1:0] CNT_WEAK = C'(1) << (C - 1);

    logic [NR_ENTRIES-1:0] valid_q;
    logic [NR_ENTRIES-1:0] lower_16_q;
    logic [63-LO:0]        tag_q    [NR_ENTRIES];
    logic [63:0]           target_q [NR_ENTRIES];
    logic [C-1:0]          cnt_q    [NR_ENTRIES];

    logic [IB-1:0] rd_idx, wr_idx;
    logic          rd_hit, wr_hit;
    logic [C-1:0]  wr_cnt, cnt_next;
    logic          unused_bits;

    assign rd_idx = vpc_i[LO-1:INDEX_OFFSET];
    assign rd_hit = valid_q[rd_idx] && tag_q[rd_idx] == vpc_i[63:LO];

    assign predict_valid_o       = rd_hit;
    assign predict_taken_o       = rd_hit && cnt_q[rd_idx][C-1];
    assign predict_address_o     = rd_hit ? target_q[rd_idx] : '0;
    assign predict_is_lower_16_o = rd_hit && lower_16_q[rd_idx];

    assign wr_idx   = branch_predict_i.pc[LO-1:INDEX_OFFSET];
    assign wr_hit   = valid_q[wr_idx] && tag_q[wr_idx] == branch_predict_i.pc[63:LO];
    assign wr_cnt   = cnt_q[wr_idx];
    assign cnt_next = branch_predict_i.is_taken ? (wr_cnt == CNT_MAX ? wr_cnt : wr_cnt + 1'b1)
                                                : (wr_cnt == '0 ? wr_cnt : wr_cnt - 1'b1);

    // mispredict flag and sub-index PC bits are carried but play no part in the table
    assign unused_bits = ^{branch_predict_i.is_mispredict, vpc_i[INDEX_OFFSET-1:0],
                           branch_predict_i.pc[INDEX_OFFSET-1:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q    <= '0;
            lower_16_q <= '0;
            for (int i = 0; i < NR_ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (branch_predict_i.valid) begin
            if (branch_predict_i.clear) begin
                valid_q[wr_idx] <= 1'b0;
            end else if (wr_hit) begin
                cnt_q[wr_idx] <= cnt_next;
                if (branch_predict_i.is_taken) begin
                    target_q[wr_idx]   <= branch_predict_i.target_address;
                    lower_16_q[wr_idx] <= branch_predict_i.is_lower_16;
                end
            end else if (branch_predict_i.is_taken) begin
                valid_q[wr_idx]    <= 1'b1;
                tag_q[wr_idx]      <= branch_predict_i.pc[63:LO];
                target_q[wr_idx]   <= branch_predict_i.target_address;
                lower_16_q[wr_idx] <= branch_predict_i.is_lower_16;
                cnt_q[wr_idx]      <= CNT_WEAK;
            end
        end
    end
endmodule
